audio_echo: RTL and testbench
=============================

AUDIO_ECHO -- requirements
Module: audio_echo

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving log2 of the delay buffer depth per channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sample_end, input, 2 bits: one-cycle strobe from the codec, audio_input valid; bit 1 = left, bit 0 = right.
REQ-005 The block SHALL have port sample_req, input, 2 bits: one-cycle strobe from the codec, next output sample wanted; bit 1 = left, bit 0 = right.
REQ-006 The block SHALL have port audio_input, input, 16 bits: signed two's-complement captured sample.
REQ-007 The block SHALL have port audio_output, output, 16 bits: signed sample for the codec.
REQ-008 The block SHALL have port enable, input, 1 bit: 1 = echo active, 0 = dry passthrough.
REQ-009 The block SHALL have port delay_len, input, ADDR_W bits: echo delay in samples per channel; 0 = no echo.
REQ-010 The block SHALL have port mix_shift, input, 3 bits: wet attenuation, right shift applied to the delayed sample for the output.
REQ-011 The block SHALL have port fb_shift, input, 3 bits: feedback attenuation, right shift applied to the delayed sample before it is written back.
REQ-012 The block SHALL have port ready, output, 1 bit: 1 when the buffer clear has finished.

Function
REQ-013 Buffer: single-port synchronous RAM, 2*2^ADDR_W x 16; address = {channel, ptr}; 1-cycle read latency.
REQ-014 Per channel c, the block SHALL hold write pointer wr_ptr[c] (ADDR_W bits), result out_reg[c] and flag pend[c].
REQ-015 sample_end[c] SHALL latch audio_input into in_reg[c] and set pend[c] on the same edge, in any state.
REQ-016 States: CLEAR, IDLE, READ, WAIT, CALC, WRITE.
REQ-017 CLEAR SHALL write 0 to addresses 0..2*2^ADDR_W-1, one per cycle, ready=0, then go to IDLE with ready=1.
REQ-018 While ready=0, in_reg[c] SHALL be copied to out_reg[c] on each sample_end[c] (dry output); pend flags are cleared.
REQ-019 IDLE SHALL select the channel to process: pend[1] takes priority over pend[0]; the selected pend is cleared on leaving IDLE.
REQ-020 READ SHALL issue rd_addr = {c, wr_ptr[c] - delay_len}, modulo 2^ADDR_W.
REQ-021 WAIT SHALL capture the RAM data as delayed.
REQ-022 CALC SHALL compute wet = delayed >>> mix_shift and fbk = delayed >>> fb_shift, both arithmetic shifts.
REQ-023 CALC SHALL force wet = fbk = 0 if delay_len == 0 or enable == 0.
REQ-024 CALC SHALL set out_reg[c] = sat16(in_reg[c] + wet) and wdata = sat16(in_reg[c] + fbk).
REQ-025 sat16: 17-bit sum, clamped to 0x7FFF / 0x8000 on overflow.
REQ-026 WRITE SHALL write wdata to {c, wr_ptr[c]}, increment wr_ptr[c] (wrap 2^ADDR_W-1 -> 0), and return to IDLE.
REQ-027 Processing latency from sample_end[c] to out_reg[c] update SHALL be at most 5 cycles with the other channel idle, and at most 9 cycles if both channels are pending.
REQ-028 On sample_req[c], audio_output SHALL be registered from out_reg[c] and be valid from the next cycle until the next sample_req.
REQ-029 If sample_req[c] coincides with the CALC update of out_reg[c], the new value SHALL be output (bypass).
REQ-030 A sample_end[c] arriving while pend[c]=1 SHALL overwrite in_reg[c]; the older sample is dropped and only one is processed.
REQ-031 Changes to delay_len, mix_shift or fb_shift SHALL take effect at the next READ/CALC; there is no glitch filtering.

Reset
REQ-032 On reset: state=CLEAR, clear address=0, wr_ptr=0, pend=0, in_reg=0, out_reg=0, audio_output=0x0000, ready=0.
REQ-033 Reset asserted mid-operation SHALL abort any access in progress, discard pending samples, and restart CLEAR from address 0.

Verification
REQ-034 Reset, then 2*2^ADDR_W cycles -> ready rises exactly after the last clear write; every RAM word reads 0.
REQ-035 enable=1, delay_len=4, mix_shift=1, fb_shift=7; left impulse 0x4000 then zeros -> left outputs 0x4000, 0, 0, 0, 0x2000, 0, ...; right channel stays 0.
REQ-036 delay_len=1, mix_shift=0, fb_shift=0; left input 0x7000 each sample -> output saturates at 0x7FFF with no wrap to negative; the same check with 0x9000 gives 0x8000.
REQ-037 ADDR_W=4, delay_len=15, 40 left samples -> the echo is correct across the wr_ptr wrap from 15 to 0.
REQ-038 Issue sample_end[1] and sample_end[0] one cycle apart -> both out_reg values are correct within 9 cycles, and audio_output follows sample_req[1]/sample_req[0].
REQ-039 Assert reset during WAIT -> ready=0, audio_output=0, and the clear sweep restarts from address 0.

Source files
------------

// File: rtl/audio_echo_if.sv
// Codec-side sample bus for audio_echo: capture/request strobes plus sample data.
// Strobe bit 1 = left channel, bit 0 = right channel.
interface audio_echo_if;
  logic [1:0]  sample_end;
  logic [1:0]  sample_req;
  logic [15:0] audio_input;
  logic [15:0] audio_output;

  modport master (
    output sample_end,
    output sample_req,
    output audio_input,
    input  audio_output
  );

  modport slave (
    input  sample_end,
    input  sample_req,
    input  audio_input,
    output audio_output
  );
endinterface

// File: rtl/audio_echo.sv
// Stereo feedback echo: one shared single-port delay RAM, two channels time-multiplexed
// through a small sequencer. Dry passthrough until the RAM clear sweep has finished.
module audio_echo #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  audio_echo_if.slave       bus,
  input  logic              enable,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [2:0]        mix_shift,
  input  logic [2:0]        fb_shift,
  output logic              ready
);

  localparam int DEPTH = 2 * (2 ** ADDR_W);

  typedef enum logic [2:0] {CLEAR, IDLE, READ, WAIT, CALC, WRITE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     clr_addr;
  logic [ADDR_W-1:0]   wr_ptr [2];
  logic [15:0]         in_reg [2];
  logic [15:0]         out_reg [2];
  logic [1:0]          pend;
  logic                ch;
  logic                sel;
  logic                take;
  logic signed [15:0]  delayed;
  logic [15:0]         wdata;
  logic signed [15:0]  wet;
  logic signed [15:0]  fbk;
  logic [15:0]         out_new;
  logic [15:0]         wb_new;
  logic                echo_on;

  logic [15:0]         mem [DEPTH];
  logic [ADDR_W:0]     ram_addr;
  logic                ram_we;
  logic [15:0]         ram_wdata;
  logic [15:0]         rdata;

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    case (s[16:15])
      2'b01:   return 16'h7FFF;
      2'b10:   return 16'h8000;
      default: return s[15:0];
    endcase
  endfunction

  assign sel  = pend[1];
  assign take = (state == IDLE) && (pend != '0);

  // Next state and RAM port mux
  always_comb begin
    state_nxt = state;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state)
      CLEAR: begin
        ram_addr = clr_addr;
        ram_we   = 1'b1;
        if (&clr_addr) state_nxt = IDLE;
      end
      IDLE:  if (take) state_nxt = READ;
      READ: begin
        ram_addr  = {ch, wr_ptr[ch] - delay_len};
        state_nxt = WAIT;
      end
      WAIT:  state_nxt = CALC;
      CALC:  state_nxt = WRITE;
      WRITE: begin
        ram_addr  = {ch, wr_ptr[ch]};
        ram_we    = 1'b1;
        ram_wdata = wdata;
        state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign echo_on = enable && (delay_len != '0);

  always_comb begin
    wet = '0;
    fbk = '0;
    if (echo_on) begin
      wet = delayed >>> mix_shift;
      fbk = delayed >>> fb_shift;
    end
  end

  assign out_new = sat16(in_reg[ch], wet);
  assign wb_new  = sat16(in_reg[ch], fbk);

  // Write is gated by reset so an access caught by reset is abandoned, not completed
  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[ram_addr] <= ram_wdata;
    rdata <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= CLEAR;
      clr_addr         <= '0;
      pend             <= '0;
      ch               <= 1'b0;
      delayed          <= '0;
      wdata            <= '0;
      ready            <= 1'b0;
      bus.audio_output <= '0;
      for (int unsigned c = 0; c < 2; c++) begin
        wr_ptr[c]  <= '0;
        in_reg[c]  <= '0;
        out_reg[c] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (state == CLEAR && state_nxt == IDLE) ready <= 1'b1;
      if (take) ch <= sel;
      if (state == WAIT) delayed <= rdata;
      if (state == CALC) begin
        out_reg[ch] <= out_new;
        wdata       <= wb_new;
      end
      if (state == WRITE) wr_ptr[ch] <= wr_ptr[ch] + 1'b1;

      // A new capture always wins over the pending-clear of the same channel
      for (int unsigned c = 0; c < 2; c++) begin
        if (bus.sample_end[c]) begin
          in_reg[c] <= bus.audio_input;
          pend[c]   <= ready;
          if (!ready) out_reg[c] <= bus.audio_input;
        end else if (take && sel == 1'(c)) begin
          pend[c] <= 1'b0;
        end
      end

      if (bus.sample_req[1])
        bus.audio_output <= (state == CALC && ch == 1'b1) ? out_new : out_reg[1];
      else if (bus.sample_req[0])
        bus.audio_output <= (state == CALC && ch == 1'b0) ? out_new : out_reg[0];
    end
  end

endmodule

// File: tb/tb_audio_echo.sv
// Directed bench for audio_echo with a 16-word-per-channel buffer.
module tb_audio_echo;
  localparam int AW    = 4;
  localparam int DEPTH = 2 * (2 ** AW);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] delay_len = '0;
  logic [2:0]    mix_shift = '0;
  logic [2:0]    fb_shift = '0;
  logic          ready;

  int n_assert = 0;
  int n_fail   = 0;

  audio_echo_if bus ();

  audio_echo #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .enable    (enable),
    .delay_len (delay_len),
    .mix_shift (mix_shift),
    .fb_shift  (fb_shift),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] clamp(input int s);
    if (s > 32767)  return 16'sh7FFF;
    if (s < -32768) return 16'sh8000;
    return 16'(s);
  endfunction

  // Called at a negedge after reset has been sampled high; releases it and times the sweep.
  task automatic clear_sweep(input string tag);
    int bad;
    reset = 1'b0;
    repeat (DEPTH - 1) @(negedge clk);
    check({tag, "_ready_early"}, 16'(ready), 16'h0);
    @(negedge clk);
    check({tag, "_ready_rise"}, 16'(ready), 16'h1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.mem[i] !== 16'h0) bad++;
    check({tag, "_mem_zero"}, 16'(bad), 16'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_sweep(tag);
  endtask

  task automatic xfer(input int ch, input logic [15:0] v, input logic [15:0] exp, input string tag);
    @(negedge clk);
    bus.sample_end  = 2'b01 << ch;
    bus.audio_input = v;
    @(negedge clk);
    bus.sample_end = '0;
    repeat (5) @(negedge clk);
    bus.sample_req = 2'b01 << ch;
    @(negedge clk);
    bus.sample_req = '0;
    check(tag, bus.audio_output, exp);
  endtask

  logic signed [15:0] mbuf [16];
  logic signed [15:0] vin, d, mw, mf, mexp;
  int mp;

  initial begin
    bus.sample_end  = '0;
    bus.sample_req  = '0;
    bus.audio_input = '0;

    // Reset state and first clear sweep
    @(negedge clk);
    check("rst_ready", 16'(ready), 16'h0);
    check("rst_out", bus.audio_output, 16'h0);
    clear_sweep("clr0");

    // Impulse response, delay 4
    enable = 1'b1; delay_len = 4; mix_shift = 1; fb_shift = 7;
    xfer(1, 16'h4000, 16'h4000, "imp0");
    xfer(1, 16'h0000, 16'h0000, "imp1");
    xfer(1, 16'h0000, 16'h0000, "imp2");
    xfer(1, 16'h0000, 16'h0000, "imp3");
    xfer(1, 16'h0000, 16'h2000, "imp4");
    xfer(1, 16'h0000, 16'h0000, "imp5");
    xfer(1, 16'h0000, 16'h0000, "imp6");
    xfer(1, 16'h0000, 16'h0000, "imp7");
    xfer(1, 16'h0000, 16'h0040, "imp8");
    xfer(0, 16'h0000, 16'h0000, "imp_right");

    // Positive saturation, then enable=0 forces dry output
    do_reset("clr1");
    enable = 1'b1; delay_len = 1; mix_shift = 0; fb_shift = 0;
    xfer(1, 16'h7000, 16'h7000, "satp0");
    xfer(1, 16'h7000, 16'h7FFF, "satp1");
    xfer(1, 16'h7000, 16'h7FFF, "satp2");
    enable = 1'b0;
    xfer(1, 16'h1000, 16'h1000, "dry_disabled");

    // Negative saturation
    do_reset("clr2");
    enable = 1'b1;
    xfer(1, 16'h9000, 16'h9000, "satn0");
    xfer(1, 16'h9000, 16'h8000, "satn1");
    xfer(1, 16'h9000, 16'h8000, "satn2");

    // Pointer wrap with delay 15 against a sample-history model
    do_reset("clr3");
    enable = 1'b1; delay_len = 15; mix_shift = 1; fb_shift = 2;
    for (int i = 0; i < 16; i++) mbuf[i] = '0;
    mp = 0;
    for (int n = 0; n < 40; n++) begin
      vin  = 16'(n * 700 - 12000);
      d    = mbuf[(mp - 15) & 15];
      mw   = d >>> 1;
      mf   = d >>> 2;
      mexp = clamp(int'(vin) + int'(mw));
      mbuf[mp] = clamp(int'(vin) + int'(mf));
      mp = (mp + 1) & 15;
      xfer(1, vin, mexp, $sformatf("wrap%0d", n));
    end
    // delay_len=0 must ignore the stale word under wr_ptr
    delay_len = 0;
    xfer(1, 16'h0000, 16'h0000, "zero_delay");

    // Both channels one cycle apart, requests timed to hit the CALC bypass
    do_reset("clr4");
    enable = 1'b1; delay_len = 4; mix_shift = 1; fb_shift = 7;
    @(negedge clk); bus.sample_end = 2'b10; bus.audio_input = 16'h1111;
    @(negedge clk); bus.sample_end = 2'b01; bus.audio_input = 16'h2222;
    @(negedge clk); bus.sample_end = 2'b00;
    @(negedge clk);
    @(negedge clk); bus.sample_req = 2'b10;
    @(negedge clk); bus.sample_req = 2'b00;
    check("dual_left_bypass", bus.audio_output, 16'h1111);
    repeat (4) @(negedge clk);
    bus.sample_req = 2'b01;
    @(negedge clk); bus.sample_req = 2'b00;
    check("dual_right_bypass", bus.audio_output, 16'h2222);
    repeat (3) @(negedge clk);
    check("dual_right_hold", bus.audio_output, 16'h2222);
    bus.sample_req = 2'b10;
    @(negedge clk); bus.sample_req = 2'b00;
    check("dual_left_again", bus.audio_output, 16'h1111);

    // Reset while the sequencer is in WAIT
    @(negedge clk); bus.sample_end = 2'b10; bus.audio_input = 16'h3333;
    @(negedge clk); bus.sample_end = 2'b00;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("wait_rst_ready", 16'(ready), 16'h0);
    check("wait_rst_out", bus.audio_output, 16'h0);
    clear_sweep("clr5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
